// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction store: word widths, the NOP encoding
// and the fixed boot image reloaded on reset.
package instruction_memory_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] NOP = 8'h00;

   // Entry 0 sits in the least significant byte.
   localparam logic [7:0][DATA_W-1:0] BOOT_IMAGE = {
      8'h87, 8'h76, 8'h65, 8'h54, 8'h43, 8'h32, 8'h21, 8'h10
   };

   // Boot value for any word index; words beyond the image boot as NOP.
   function automatic logic [DATA_W-1:0] boot_word(input int unsigned idx);
      logic [DATA_W-1:0] w;
      case (idx)
         0:       w = BOOT_IMAGE[0];
         1:       w = BOOT_IMAGE[1];
         2:       w = BOOT_IMAGE[2];
         3:       w = BOOT_IMAGE[3];
         4:       w = BOOT_IMAGE[4];
         5:       w = BOOT_IMAGE[5];
         6:       w = BOOT_IMAGE[6];
         7:       w = BOOT_IMAGE[7];
         default: w = NOP;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instruction_memory.sv
// Flop-based instruction store with a combinational fetch port and a boot
// image reloaded on reset. Define INSTRUCTION_MEMORY_LOAD_EN to add a write port.
module instruction_memory
   import instruction_memory_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] instruction,
   output logic              addr_err
`ifdef INSTRUCTION_MEMORY_LOAD_EN
   ,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
`endif
);

   logic [DATA_W-1:0] words [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      localparam logic [DATA_W-1:0] INIT = boot_word(i);
      logic [DATA_W-1:0] word_q;

      // Reset wins over a simultaneous write; out-of-range writes match no word.
      always_ff @(posedge clk) begin
         if (reset) begin
            word_q <= INIT;
`ifdef INSTRUCTION_MEMORY_LOAD_EN
         end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
            word_q <= wr_data;
`endif
         end
      end

      assign words[i] = word_q;
   end

   assign addr_err = (32'(pc) >= DEPTH);

   always_comb begin
      instruction = NOP;
      for (int i = 0; i < DEPTH; i++) begin
         if (pc == ADDR_W'(i)) instruction = words[i];
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: three depths side by side,
// directed vectors, load-port corner cases and a randomized model comparison.
module tb_instruction_memory;

`ifdef INSTRUCTION_MEMORY_LOAD_EN
   localparam bit LOAD = 1'b1;
`else
   localparam bit LOAD = 1'b0;
`endif

   localparam int N = 3;
   int dep [N] = '{256, 64, 5};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] pc = 8'd0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_addr = 8'd0;
   logic [7:0] wr_data = 8'd0;

   logic [7:0] instr [N];
   logic       err   [N];

   logic [7:0] boot [8] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
   logic [7:0] model [N][256];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   instruction_memory #(.DEPTH(256)) dut_256 (
      .clk(clk), .reset(reset), .pc(pc), .instruction(instr[0]), .addr_err(err[0])
`ifdef INSTRUCTION_MEMORY_LOAD_EN
      , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
   );

   instruction_memory #(.DEPTH(64)) dut_64 (
      .clk(clk), .reset(reset), .pc(pc), .instruction(instr[1]), .addr_err(err[1])
`ifdef INSTRUCTION_MEMORY_LOAD_EN
      , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
   );

   instruction_memory #(.DEPTH(5)) dut_5 (
      .clk(clk), .reset(reset), .pc(pc), .instruction(instr[2]), .addr_err(err[2])
`ifdef INSTRUCTION_MEMORY_LOAD_EN
      , .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`endif
   );

   typedef struct {
      logic [7:0] pc;
      logic [7:0] i256;
      logic       e256;
      logic [7:0] i64;
      logic       e64;
   } vec_t;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s pc=%0d got=%h want=%h", name, pc, act, exp);
      end
   endtask

   // Reference memory behaviour applied for the edge about to happen.
   task automatic model_edge();
      for (int k = 0; k < N; k++) begin
         if (reset) begin
            for (int a = 0; a < 256; a++) model[k][a] = (a < 8) ? boot[a] : 8'h00;
         end else if (LOAD && wr_en && (int'(wr_addr) < dep[k])) begin
            model[k][wr_addr] = wr_data;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string name);
      for (int k = 0; k < N; k++) begin
         if (int'(pc) < dep[k]) begin
            check({name, "_instr"}, instr[k], model[k][pc]);
            check({name, "_err"}, {7'd0, err[k]}, 8'd0);
         end else begin
            check({name, "_instr"}, instr[k], 8'h00);
            check({name, "_err"}, {7'd0, err[k]}, 8'd1);
         end
      end
   endtask

   initial begin
      vec_t vecs [12];
      for (int i = 0; i < 8; i++) vecs[i] = '{8'(i), boot[i], 1'b0, boot[i], 1'b0};
      vecs[8]  = '{8'd100, 8'h00, 1'b0, 8'h00, 1'b1};
      vecs[9]  = '{8'd63,  8'h00, 1'b0, 8'h00, 1'b0};
      vecs[10] = '{8'd64,  8'h00, 1'b0, 8'h00, 1'b1};
      vecs[11] = '{8'd255, 8'h00, 1'b0, 8'h00, 1'b1};

      @(negedge clk);
      reset = 1'b1;
      tick();
      reset = 1'b0;

      foreach (vecs[i]) begin
         pc = vecs[i].pc;
         #5;
         check("tbl_i256", instr[0], vecs[i].i256);
         check("tbl_e256", {7'd0, err[0]}, {7'd0, vecs[i].e256});
         check("tbl_i64", instr[1], vecs[i].i64);
         check("tbl_e64", {7'd0, err[1]}, {7'd0, vecs[i].e64});
         check("tbl_i5", instr[2], (int'(vecs[i].pc) < 5) ? boot[vecs[i].pc[2:0]] : 8'h00);
         check("tbl_e5", {7'd0, err[2]}, (int'(vecs[i].pc) < 5) ? 8'd0 : 8'd1);
      end

      @(negedge clk);
      tick();

      if (LOAD) begin
         // Write then read at the same address: old data until the edge.
         pc = 8'd3; wr_en = 1'b1; wr_addr = 8'd3; wr_data = 8'hA5;
         #1;
         check("wr_before", instr[0], 8'h43);
         tick();
         wr_en = 1'b0;
         check("wr_after256", instr[0], 8'hA5);
         check("wr_after64", instr[1], 8'hA5);

         // Reset beats a simultaneous write.
         reset = 1'b1; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'hFF; pc = 8'd0;
         tick();
         reset = 1'b0; wr_en = 1'b0;
         check("rst_prio", instr[0], 8'h10);
         pc = 8'd3; #1;
         check("rst_clears", instr[0], 8'h43);

         // Out-of-range write for DEPTH=64 leaves it untouched.
         wr_en = 1'b1; wr_addr = 8'd200; wr_data = 8'h99;
         tick();
         wr_en = 1'b0;
         for (int a = 0; a < 64; a++) begin
            pc = 8'(a); #1;
            check("oor_sweep64", instr[1], (a < 8) ? boot[a] : 8'h00);
         end
         pc = 8'd200; #1;
         check("inrange_256", instr[0], 8'h99);
         check("oor_read64", instr[1], 8'h00);

         // Reset restores a rewritten boot word.
         wr_en = 1'b1; wr_addr = 8'd7; wr_data = 8'h5A; pc = 8'd7;
         tick();
         wr_en = 1'b0;
         check("w7", instr[0], 8'h5A);
         reset = 1'b1;
         tick();
         reset = 1'b0;
         check("w7_reboot", instr[0], 8'h87);
      end else begin
         // ROM build: writes have no port; content must stay the boot image.
         pc = 8'd7; #1;
         check("rom7", instr[0], 8'h87);
         pc = 8'd4; #1;
         check("rom4_d5", instr[2], 8'h54);
      end

      for (int c = 0; c < 400; c++) begin
         reset   = ($urandom_range(0, 31) == 0);
         wr_en   = ($urandom_range(0, 1) == 1);
         wr_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
         wr_data = 8'($urandom);
         pc      = ($urandom_range(0, 1) == 1) ? wr_addr : 8'($urandom);
         #1;
         check_model("rnd_pre");
         tick();
         check_model("rnd_post");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
